// File: rtl/mp_cache_l2_tag_ctrl.sv
// Requester-side controller for the L2 tag SRAM (1RW port 0 + 1R port 1).
// Define MP_L2_TAG_INIT_EN to clear the array after reset (INIT sweep + DISARM).
module mp_cache_l2_tag_ctrl #(
  parameter int unsigned TAG_WIDTH   = 22,
  parameter int unsigned INDEX_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   lkp_valid,
  output logic                   lkp_ready,
  input  logic [INDEX_WIDTH-1:0] lkp_index,
  input  logic [TAG_WIDTH-1:0]   lkp_tag,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_hit,
  output logic                   rsp_dirty,
  output logic [TAG_WIDTH-1:0]   rsp_tag,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic [INDEX_WIDTH-1:0] upd_index,
  input  logic [1:0]             upd_op,
  input  logic [TAG_WIDTH-1:0]   upd_tag,
  output logic                   init_done,
  output logic                   tag_csb0,
  output logic                   tag_web0,
  output logic [INDEX_WIDTH-1:0] tag_addr0,
  output logic [TAG_WIDTH+1:0]   tag_din0,
  output logic                   tag_csb1,
  output logic [INDEX_WIDTH-1:0] tag_addr1,
  input  logic [TAG_WIDTH+1:0]   tag_dout1
);

  localparam int unsigned SETS   = 1 << INDEX_WIDTH;
  localparam int unsigned WORD_W = TAG_WIDTH + 2;

  typedef enum logic [1:0] {ST_INIT, ST_DISARM, ST_RUN} state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] init_idx_q, init_idx_d;
  logic                   init_done_q;
  logic                   disarm_pending_q;
  logic                   upd_acc, lkp_acc;
  logic                   rd_pending_q;
  logic                   rsp_land;
  logic [TAG_WIDTH-1:0]   lkp_tag_q;
  logic                   rsp_valid_q, rsp_hit_q, rsp_dirty_q;
  logic [TAG_WIDTH-1:0]   rsp_tag_q;
  logic [WORD_W-1:0]      upd_word;

  // Entry written by each update op: fill clean, fill dirty, mark dirty, invalidate.
  always_comb begin
    upd_word = '0;
    case (upd_op)
      2'b00:   upd_word = {1'b1, 1'b0, upd_tag};
      2'b01:   upd_word = {1'b1, 1'b1, upd_tag};
      2'b10:   upd_word = {1'b1, 1'b1, upd_tag};
      default: upd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_INIT;
      init_idx_q       <= '0;
      init_done_q      <= 1'b0;
      disarm_pending_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      init_idx_q       <= init_idx_d;
      init_done_q      <= (state_d == ST_RUN);
      disarm_pending_q <= upd_acc;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    upd_ready  = 1'b0;
    lkp_ready  = 1'b0;
    upd_acc    = 1'b0;
    lkp_acc    = 1'b0;
    tag_csb0   = 1'b1;
    tag_web0   = 1'b1;
    tag_addr0  = '0;
    tag_din0   = '0;
    tag_csb1   = 1'b1;
    tag_addr1  = '0;
    case (state_q)
      ST_INIT: begin
`ifdef MP_L2_TAG_INIT_EN
        tag_csb0   = 1'b0;
        tag_web0   = 1'b0;
        tag_addr0  = init_idx_q;
        init_idx_d = init_idx_q + INDEX_WIDTH'(1);
        if (init_idx_q == INDEX_WIDTH'(SETS - 1)) state_d = ST_DISARM;
`else
        state_d = ST_RUN;
`endif
      end
      // Dummy read so the SRAM's sticky web0 register no longer holds a write.
      ST_DISARM: begin
        tag_csb0 = 1'b0;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        upd_ready = !disarm_pending_q;
        lkp_ready = !upd_valid && !disarm_pending_q && (!rsp_valid_q || rsp_ready);
        upd_acc   = upd_valid && upd_ready;
        lkp_acc   = lkp_valid && lkp_ready;
        if (disarm_pending_q) begin
          tag_csb0 = 1'b0;
        end else if (upd_acc) begin
          tag_csb0  = 1'b0;
          tag_web0  = 1'b0;
          tag_addr0 = upd_index;
          tag_din0  = upd_word;
        end
        if (lkp_acc) begin
          tag_csb1  = 1'b0;
          tag_addr1 = lkp_index;
        end
      end
      default: state_d = ST_INIT;
    endcase
    // Keep the SRAM deselected while reset is held.
    if (!rst_n) begin
      tag_csb0 = 1'b1;
      tag_web0 = 1'b1;
      tag_csb1 = 1'b1;
    end
  end

  // A captured read lands once the response slot is free; the SRAM holds dout1
  // meanwhile because no new read can be accepted while the slot is blocked.
  assign rsp_land = rd_pending_q && (!rsp_valid_q || rsp_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending_q <= 1'b0;
      lkp_tag_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_dirty_q  <= 1'b0;
      rsp_tag_q    <= '0;
    end else begin
      rd_pending_q <= lkp_acc || (rd_pending_q && !rsp_land);
      if (lkp_acc) lkp_tag_q <= lkp_tag;
      if (rsp_land) begin
        rsp_valid_q <= 1'b1;
        rsp_hit_q   <= tag_dout1[TAG_WIDTH+1] && (tag_dout1[TAG_WIDTH-1:0] == lkp_tag_q);
        rsp_dirty_q <= tag_dout1[TAG_WIDTH+1] && tag_dout1[TAG_WIDTH];
        rsp_tag_q   <= tag_dout1[TAG_WIDTH-1:0];
      end else if (rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_dirty = rsp_dirty_q;
  assign rsp_tag   = rsp_tag_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_mp_cache_l2_tag_ctrl.sv
// Bench for mp_cache_l2_tag_ctrl with a behavioural 1RW+1R tag SRAM and a response scoreboard.
`timescale 1ns/1ps
module tb_mp_cache_l2_tag_ctrl;
  localparam int unsigned TW   = 22;
  localparam int unsigned IW   = 4;
  localparam int unsigned SETS = 16;
`ifdef MP_L2_TAG_INIT_EN
  localparam int INIT_EDGES = 17;
  localparam int INIT_WR    = 16;
  localparam int INIT_DIS   = 1;
`else
  localparam int INIT_EDGES = 1;
  localparam int INIT_WR    = 0;
  localparam int INIT_DIS   = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic lkp_valid, lkp_ready, rsp_valid, rsp_ready, rsp_hit, rsp_dirty;
  logic [IW-1:0] lkp_index, upd_index, tag_addr0, tag_addr1;
  logic [TW-1:0] lkp_tag, rsp_tag, upd_tag;
  logic upd_valid, upd_ready, init_done, tag_csb0, tag_web0, tag_csb1;
  logic [1:0] upd_op;
  logic [TW+1:0] tag_din0, tag_dout1;

  always #5 clk = ~clk;

  mp_cache_l2_tag_ctrl #(.TAG_WIDTH(TW), .INDEX_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_index(lkp_index), .lkp_tag(lkp_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_dirty(rsp_dirty),
    .rsp_tag(rsp_tag),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index), .upd_op(upd_op),
    .upd_tag(upd_tag), .init_done(init_done),
    .tag_csb0(tag_csb0), .tag_web0(tag_web0), .tag_addr0(tag_addr0), .tag_din0(tag_din0),
    .tag_csb1(tag_csb1), .tag_addr1(tag_addr1), .tag_dout1(tag_dout1)
  );

  // SRAM: inputs captured at the edge, write committed at the following edge, sticky web0.
  logic [TW+1:0] mem [SETS];
  logic          csb0_r = 1'b1;
  logic          web0_r = 1'b1;
  logic [IW-1:0] addr0_r;
  logic [TW+1:0] din0_r;
  int            wr_caps, zero_caps, dis_caps;

  always @(posedge clk) begin
    if (!csb0_r && !web0_r) mem[addr0_r] <= din0_r;
    csb0_r <= tag_csb0;
    if (!tag_csb0) begin
      web0_r  <= tag_web0;
      addr0_r <= tag_addr0;
      din0_r  <= tag_din0;
    end
    if (!tag_csb1) tag_dout1 <= mem[tag_addr1];
    if (!rst_n) begin
      wr_caps <= 0; zero_caps <= 0; dis_caps <= 0;
    end else if (!tag_csb0) begin
      if (!tag_web0) wr_caps <= wr_caps + 1;
      if (!tag_web0 && tag_din0 == '0) zero_caps <= zero_caps + 1;
      if (tag_web0) dis_caps <= dis_caps + 1;
    end
  end

  typedef struct {
    logic          is_upd;
    logic [IW-1:0] idx;
    logic [1:0]    op;
    logic [TW-1:0] tag;
    logic [TW+1:0] exp;   // {hit, dirty, tag}
  } vec_t;

  vec_t          vecs [17];
  logic [TW+1:0] sb [$];
  int            vectors = 0;
  int            miscompares = 0;
  logic          hold_q = 1'b0;
  logic [TW+1:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample point one time unit before each posedge; also runs the response monitor.
  task automatic sample();
    logic [TW+1:0] e;
    #4;
    if (rst_n) begin
      if (hold_q) begin
        check("rsp_held_valid", 64'(rsp_valid), 64'd1);
        check("rsp_held_data", 64'({rsp_hit, rsp_dirty, rsp_tag}), 64'(held));
      end
      if (rsp_valid && rsp_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL rsp_unexpected: got %0h expected no response",
                   {rsp_hit, rsp_dirty, rsp_tag});
        end else begin
          vectors--;
          e = sb.pop_front();
          check("rsp", 64'({rsp_hit, rsp_dirty, rsp_tag}), 64'(e));
        end
      end
      hold_q = rsp_valid && !rsp_ready;
      held   = {rsp_hit, rsp_dirty, rsp_tag};
    end else begin
      hold_q = 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge clk); sample();
  endtask

  task automatic do_upd(input logic [IW-1:0] idx, input logic [1:0] op, input logic [TW-1:0] tag);
    @(negedge clk);
    upd_valid = 1'b1; upd_index = idx; upd_op = op; upd_tag = tag;
    sample();
    for (int i = 0; i < 20 && !upd_ready; i++) begin @(negedge clk); sample(); end
    check("upd_accept", 64'(upd_ready), 64'd1);
    @(negedge clk); upd_valid = 1'b0; sample();
  endtask

  task automatic do_lkp(input logic [IW-1:0] idx, input logic [TW-1:0] tag, input logic [TW+1:0] exp);
    @(negedge clk);
    lkp_valid = 1'b1; lkp_index = idx; lkp_tag = tag;
    sample();
    for (int i = 0; i < 20 && !lkp_ready; i++) begin @(negedge clk); sample(); end
    check("lkp_accept", 64'(lkp_ready), 64'd1);
    if (lkp_ready) sb.push_back(exp);
    @(negedge clk); lkp_valid = 1'b0; sample();
  endtask

  task automatic reset_and_init();
    @(negedge clk); rst_n = 1'b0; #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'({rsp_hit, rsp_dirty, rsp_tag}), 64'd0);
    check("rst_readies", 64'({lkp_ready, upd_ready, init_done}), 64'd0);
    check("rst_sram_pins", 64'({tag_csb0, tag_web0, tag_csb1}), 64'b111);
    sb.delete();
    hold_q = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sample();
    for (int e = 1; e < INIT_EDGES; e++) begin @(negedge clk); sample(); end
    check("init_done_early", 64'(init_done), 64'd0);
    @(negedge clk); sample();
    check("init_done", 64'(init_done), 64'd1);
    check("init_writes", 64'(wr_caps), 64'(INIT_WR));
    check("init_zero_writes", 64'(zero_caps), 64'(INIT_WR));
    check("init_disarm", 64'(dis_caps), 64'(INIT_DIS));
    check("run_upd_ready", 64'(upd_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int           issued;
    logic [IW-1:0] bp_idx [4];
    logic [TW-1:0] bp_tag [4];
    logic [TW+1:0] bp_exp [4];

    vecs[0]  = '{1'b1, 4'd3,  2'b00, 22'h2A5A5A, '0};
    vecs[1]  = '{1'b0, 4'd3,  2'b00, 22'h2A5A5A, {1'b1, 1'b0, 22'h2A5A5A}};
    vecs[2]  = '{1'b1, 4'd7,  2'b01, 22'h001234, '0};
    vecs[3]  = '{1'b0, 4'd7,  2'b00, 22'h001235, {1'b0, 1'b1, 22'h001234}};
    vecs[4]  = '{1'b0, 4'd7,  2'b00, 22'h001234, {1'b1, 1'b1, 22'h001234}};
    vecs[5]  = '{1'b1, 4'd3,  2'b10, 22'h2A5A5A, '0};
    vecs[6]  = '{1'b0, 4'd3,  2'b00, 22'h2A5A5A, {1'b1, 1'b1, 22'h2A5A5A}};
    vecs[7]  = '{1'b0, 4'd3,  2'b00, 22'h2A5A5B, {1'b0, 1'b1, 22'h2A5A5A}};
    vecs[8]  = '{1'b1, 4'd7,  2'b11, 22'h001234, '0};
    vecs[9]  = '{1'b0, 4'd7,  2'b00, 22'h001234, {1'b0, 1'b0, 22'h000000}};
    vecs[10] = '{1'b1, 4'd15, 2'b00, 22'h3FFFFF, '0};
    vecs[11] = '{1'b0, 4'd15, 2'b00, 22'h3FFFFF, {1'b1, 1'b0, 22'h3FFFFF}};
    vecs[12] = '{1'b0, 4'd15, 2'b00, 22'h3FFFFE, {1'b0, 1'b0, 22'h3FFFFF}};
    vecs[13] = '{1'b1, 4'd0,  2'b01, 22'h000000, '0};
    vecs[14] = '{1'b0, 4'd0,  2'b00, 22'h000000, {1'b1, 1'b1, 22'h000000}};
    vecs[15] = '{1'b1, 4'd9,  2'b10, 22'h0ABCDE, '0};
    vecs[16] = '{1'b0, 4'd9,  2'b00, 22'h0ABCDE, {1'b1, 1'b1, 22'h0ABCDE}};

    rst_n = 1'b1; lkp_valid = 1'b0; lkp_index = '0; lkp_tag = '0; rsp_ready = 1'b1;
    upd_valid = 1'b0; upd_index = '0; upd_op = '0; upd_tag = '0;
    reset_and_init();

`ifndef MP_L2_TAG_INIT_EN
    // Without the sweep the array is undefined: clear it through the update port.
    for (int i = 0; i < SETS; i++) do_upd(IW'(i), 2'b11, '0);
`endif
    for (int i = 0; i < SETS; i++) do_lkp(IW'(i), '0, '0);
    idle();

    for (int v = 0; v < 17; v++) begin
      if (vecs[v].is_upd) begin
        do_upd(vecs[v].idx, vecs[v].op, vecs[v].tag);
      end else begin
        do_lkp(vecs[v].idx, vecs[v].tag, vecs[v].exp);
        check("lat_not_early", 64'(rsp_valid), 64'd0);
        idle();
        check("lat_one_cycle", 64'(rsp_valid), 64'd1);
      end
    end

    // Collision on idx 5: update wins, lookup stalls through the disarm cycle.
    @(negedge clk);
    upd_valid = 1'b1; upd_index = 4'd5; upd_op = 2'b00; upd_tag = 22'h155555;
    lkp_valid = 1'b1; lkp_index = 4'd5; lkp_tag = 22'h155555;
    sample();
    check("col_upd_ready", 64'(upd_ready), 64'd1);
    check("col_lkp_stall0", 64'(lkp_ready), 64'd0);
    check("col_write_pins", 64'({tag_csb0, tag_web0}), 64'b00);
    @(negedge clk); upd_valid = 1'b0; sample();
    check("col_lkp_stall1", 64'(lkp_ready), 64'd0);
    check("col_disarm_pins", 64'({tag_csb0, tag_web0}), 64'b01);
    @(negedge clk); sample();
    check("col_sram_web0", 64'(web0_r), 64'd1);
    check("col_lkp_go", 64'(lkp_ready), 64'd1);
    if (lkp_ready) sb.push_back({1'b1, 1'b0, 22'h155555});
    @(negedge clk); lkp_valid = 1'b0; sample();
    idle();

    // Backpressure: four back-to-back lookups with the consumer stalled.
    bp_idx = '{4'd3, 4'd7, 4'd15, 4'd0};
    bp_tag = '{22'h2A5A5A, 22'h000000, 22'h3FFFFF, 22'h000000};
    bp_exp = '{{1'b1, 1'b1, 22'h2A5A5A}, {1'b0, 1'b0, 22'h000000},
               {1'b1, 1'b0, 22'h3FFFFF}, {1'b1, 1'b1, 22'h000000}};
    issued = 0;
    for (int c = 0; c < 40 && (issued < 4 || sb.size() > 0); c++) begin
      @(negedge clk);
      rsp_ready = (c >= 5);
      lkp_valid = (issued < 4);
      if (issued < 4) begin lkp_index = bp_idx[issued]; lkp_tag = bp_tag[issued]; end
      sample();
      if (rsp_valid && !rsp_ready) check("bp_lkp_stall", 64'(lkp_ready), 64'd0);
      if (lkp_valid && lkp_ready) begin sb.push_back(bp_exp[issued]); issued++; end
    end
    check("bp_issued", 64'(issued), 64'd4);
    check("bp_drained", 64'(sb.size()), 64'd0);
    @(negedge clk); lkp_valid = 1'b0; rsp_ready = 1'b1; sample();

    // Reset while a response is being held.
    rsp_ready = 1'b0;
    do_lkp(4'd3, 22'h2A5A5A, {1'b1, 1'b1, 22'h2A5A5A});
    idle();
    check("pre_reset_rsp_valid", 64'(rsp_valid), 64'd1);
    reset_and_init();
    rsp_ready = 1'b1;
`ifdef MP_L2_TAG_INIT_EN
    do_lkp(4'd3, 22'h2A5A5A, {1'b0, 1'b0, 22'h000000});
`else
    do_lkp(4'd3, 22'h2A5A5A, {1'b1, 1'b1, 22'h2A5A5A});
`endif
    repeat (3) idle();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
